shift_add_mul: RTL and testbench
================================

# shift_add_mul

Sequential shift-add multiplier: the multiply counterpart of the team's restoring divider, used to rebuild and check dividend = quotient × divisor + remainder. Takes two unsigned W-bit operands on a load pulse and produces a 2W-bit product after exactly W iteration cycles. A start/busy/done handshake exposes its internal registers for the lab bench display.

## Interface
- W, 4, operand width in bits (≥2); product width is 2W
- CW, $clog2(W)+1 (derived localparam), iteration counter width
- clk  input  1  clock, all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- ld  input  1  load/start; sampled only in IDLE or DONE
- a  input  W  multiplicand
- b  input  W  multiplier
- ra  output  2W  multiplicand register (zero-extended, shifted left each iteration)
- rb  output  W  multiplier register (shifted right each iteration)
- ry  output  2W  product/accumulator register
- q  output  CW  iteration counter
- busy  output  1  high while in RUN
- done  output  1  high in DONE; product on ry valid

## Operation
- States: IDLE, RUN, DONE. Reset value: IDLE; ra, rb, ry, q = 0; busy = 0; done = 0.
- IDLE/DONE with ld=1: ra ← {W'b0, a}; rb ← b; ry ← 0; q ← 0; → RUN.
- IDLE/DONE with ld=0: hold all registers and state.
- RUN, each cycle: if rb[0]=1 then ry ← ry + ra (2W-bit add, no carry-out); ra ← ra << 1 (zero-fill, MSB dropped); rb ← rb >> 1 (zero-fill); q ← q + 1.
- RUN with q = W−1: the iteration above still executes; → DONE.
- ld while in RUN: ignored; the operation in flight completes unchanged.
- No early termination: always exactly W iterations, even when rb reaches 0 early (ry then holds).
- Width rule: max product (2^W−1)² < 2^(2W), so ry never overflows; ra's dropped MSBs are always zero within W shifts.
- busy = (state==RUN); done = (state==DONE); both registered-state decodes, never both high.
- rst has priority over ld and over every state; reset mid-RUN aborts to IDLE with all outputs zero on the next edge.

## Timing
- Edge k: ld=1 sampled in IDLE/DONE → after edge k: state RUN, busy=1, q=0.
- Edges k+1 … k+W: iterations 0 … W−1.
- After edge k+W: state DONE, done=1, busy=0, ry = a×b, q = W, rb = 0.
- Latency ld→done: W+1 edges (5 at W=4). Throughput: one product per W+1 cycles with ld held or re-pulsed in DONE.
- ld held high continuously: restarts on the edge after DONE is reached (DONE lasts one cycle).
- done and ry remain stable in DONE until the next accepted ld or rst.
- rst=1 and ld=1 on same edge: reset wins.

## Structure
- Shared package arith_pkg: state typedef (IDLE, RUN, DONE) and default width constant W=4, shared with the divider.
- One sub-module: shift_add_mul_ctrl, holding the FSM and counter q, with inputs ld and rst and outputs busy, done, load strobe and step strobe. The datapath registers (ra, rb, ry) live in the top level.

## Test plan
- Reset, then ld with a=11, b=2 → busy for 4 cycles; done after 5th edge; ry=22 (0x16), q=4, rb=0.
- a=15, b=15 → ry=225 (0xE1), no overflow; ra=0xF0 at done.
- a=0, b=9 and a=9, b=0 → ry=0 in both cases; full 4 iterations still taken (done on 5th edge).
- ld re-asserted at 2nd RUN cycle with a=3, b=3 during a 7×5 run → ry=35; new operands not loaded.
- rst pulsed at 2nd RUN cycle → next edge: IDLE, all outputs 0. Fresh ld of 6×7 → ry=42.
- Divider cross-check: quotient 5 × divisor 2 → ry=10; bench adds remainder 1 → 11. Back-to-back ld in DONE yields consecutive correct products.

Source files
------------

// File: rtl/arith_pkg.sv
// Shared definitions for the shift-add multiplier and the restoring divider.
package arith_pkg;

    localparam int ARITH_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/shift_add_mul_ctrl.sv
// Sequencer for the shift-add multiplier: IDLE/RUN/DONE FSM plus iteration counter.
module shift_add_mul_ctrl
    import arith_pkg::*;
#(
    parameter int W  = ARITH_W,
    parameter int CW = $clog2(W) + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          ld,
    output logic          busy,
    output logic          done,
    output logic          load,
    output logic          step,
    output logic [CW-1:0] q
);

    state_t state;

    // ld only matters outside RUN; an operation in flight is never disturbed.
    assign load = ld && (state != RUN);
    assign step = (state == RUN);
    assign busy = (state == RUN);
    assign done = (state == DONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            q     <= '0;
        end else begin
            case (state)
                RUN: begin
                    q <= q + 1'b1;
                    if (q == CW'(W - 1))
                        state <= DONE;
                end
                default: begin
                    if (ld) begin
                        state <= RUN;
                        q     <= '0;
                    end
                end
            endcase
        end
    end

endmodule

// File: rtl/shift_add_mul.sv
// Unsigned W x W -> 2W shift-add multiplier; W iterations per product.
module shift_add_mul
    import arith_pkg::*;
#(
    parameter  int W  = ARITH_W,
    localparam int CW = $clog2(W) + 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            ld,
    input  logic [W-1:0]    a,
    input  logic [W-1:0]    b,
    output logic [2*W-1:0]  ra,
    output logic [W-1:0]    rb,
    output logic [2*W-1:0]  ry,
    output logic [CW-1:0]   q,
    output logic            busy,
    output logic            done
);

    logic load;
    logic step;

    shift_add_mul_ctrl #(.W(W), .CW(CW)) u_ctrl (
        .clk  (clk),
        .rst  (rst),
        .ld   (ld),
        .busy (busy),
        .done (done),
        .load (load),
        .step (step),
        .q    (q)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            ra <= '0;
            rb <= '0;
            ry <= '0;
        end else if (load) begin
            ra <= {{W{1'b0}}, a};
            rb <= b;
            ry <= '0;
        end else if (step) begin
            // Product fits in 2W bits, so the add never needs a carry-out.
            if (rb[0])
                ry <= ry + ra;
            ra <= ra << 1;
            rb <= rb >> 1;
        end
    end

endmodule

// File: tb/tb_shift_add_mul.sv
// Self-checking bench for shift_add_mul against a plain-arithmetic product model.
module tb_shift_add_mul;

    localparam int W  = 4;
    localparam int CW = $clog2(W) + 1;

    logic            clk = 1'b0;
    logic            rst;
    logic            ld;
    logic [W-1:0]    a;
    logic [W-1:0]    b;
    logic [2*W-1:0]  ra;
    logic [W-1:0]    rb;
    logic [2*W-1:0]  ry;
    logic [CW-1:0]   q;
    logic            busy;
    logic            done;

    int n_chk = 0;
    int n_err = 0;

    shift_add_mul #(.W(W)) dut (
        .clk  (clk),
        .rst  (rst),
        .ld   (ld),
        .a    (a),
        .b    (b),
        .ra   (ra),
        .rb   (rb),
        .ry   (ry),
        .q    (q),
        .busy (busy),
        .done (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input longint got, input longint exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Pulse ld for one edge; returns at the negedge after the load edge.
    task automatic start(input int x, input int y);
        @(negedge clk);
        ld = 1'b1; a = W'(x); b = W'(y);
        @(negedge clk);
        ld = 1'b0;
    endtask

    // Called right after the load edge; walks the W RUN cycles and checks the DONE result.
    task automatic finish(input string tag, input int x, input int y);
        longint prod, ra_exp;
        prod   = longint'(x) * longint'(y);
        ra_exp = (longint'(x) << W) % (longint'(1) << (2 * W));
        chk({tag, ".busy0"}, busy, 1);
        chk({tag, ".q0"}, q, 0);
        for (int i = 1; i < W; i++) begin
            @(negedge clk);
            chk({tag, ".busy"}, busy, 1);
            chk({tag, ".q"}, q, i);
        end
        @(negedge clk);
        chk({tag, ".done"}, done, 1);
        chk({tag, ".nbusy"}, busy, 0);
        chk({tag, ".ry"}, ry, prod);
        chk({tag, ".qW"}, q, W);
        chk({tag, ".rb"}, rb, 0);
        chk({tag, ".ra"}, ra, ra_exp);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, ".ra"}, ra, 0);
        chk({tag, ".rb"}, rb, 0);
        chk({tag, ".ry"}, ry, 0);
        chk({tag, ".q"}, q, 0);
        chk({tag, ".busy"}, busy, 0);
        chk({tag, ".done"}, done, 0);
    endtask

    initial begin
        rst = 1'b1; ld = 1'b0; a = '0; b = '0;
        repeat (2) @(negedge clk);
        check_zero("reset");
        // reset beats a simultaneous ld
        ld = 1'b1; a = 4'd5; b = 4'd5;
        @(negedge clk);
        check_zero("rst_ld");
        rst = 1'b0; ld = 1'b0;

        start(11, 2);  finish("m11x2", 11, 2);
        // DONE holds with ld low
        repeat (2) @(negedge clk);
        chk("hold.done", done, 1);
        chk("hold.ry", ry, 22);

        start(15, 15); finish("m15x15", 15, 15);
        start(0, 9);   finish("m0x9", 0, 9);
        start(9, 0);   finish("m9x0", 9, 0);

        // ld during RUN is ignored
        start(7, 5);
        ld = 1'b1; a = 4'd3; b = 4'd3;
        @(negedge clk);
        ld = 1'b0;
        chk("ignore.q1", q, 1);
        begin
            int n = 0;
            while (!done && n < 20) begin
                @(negedge clk);
                n++;
            end
            chk("ignore.lat", n, W - 1);
        end
        chk("ignore.ry", ry, 35);

        // reset mid-RUN aborts to IDLE
        start(13, 11);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_zero("abort");
        start(6, 7);   finish("m6x7", 6, 7);

        // divider cross-check: quotient 5 * divisor 2 + remainder 1
        start(5, 2);   finish("div", 5, 2);
        chk("div.rebuild", ry + 1, 11);

        // ld held high: restarts on the edge after DONE
        @(negedge clk);
        ld = 1'b1; a = 4'd12; b = 4'd13;
        @(negedge clk);
        finish("held1", 12, 13);
        @(negedge clk);
        chk("held.restart", busy, 1);
        chk("held.rq", q, 0);
        ld = 1'b0;
        for (int i = 1; i < W; i++) @(negedge clk);
        @(negedge clk);
        chk("held2.done", done, 1);
        chk("held2.ry", ry, 156);

        // randomized back-to-back products
        for (int t = 0; t < 20; t++) begin
            int x, y;
            x = int'($urandom_range(0, (1 << W) - 1));
            y = int'($urandom_range(0, (1 << W) - 1));
            start(x, y);
            finish($sformatf("rnd%0d", t), x, y);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end

endmodule
